// File: rtl/seg7_pkg.sv
// Shared types for the 7-segment display scheduler.
// State encoding, blank pattern and index-width helper.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_display_scheduler_if.sv
// Bus between pattern sources and the display scheduler.
// Ports: req/seg/urgent toward scheduler; seg/grant/busy/tick back.
interface seg7_display_scheduler_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_i;
  logic [7*NUM_REQ-1:0] seg_i;
  logic                 urgent_i;
  logic [6:0]           seg_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;
  logic                 tick_o;

  modport master (
    output req_i, seg_i, urgent_i,
    input  seg_o, grant_o, busy_o, tick_o
  );

  modport slave (
    input  req_i, seg_i, urgent_i,
    output seg_o, grant_o, busy_o, tick_o
  );

endinterface

// File: rtl/seg7_rr_picker.sv
// Round-robin channel picker, purely combinational.
// In: req, ptr (last owner), force0. Out: valid, idx.
module seg7_rr_picker
  import seg7_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               force0,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest
  // requester after ptr is the last write.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    if (!(force0 && req[0])) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = IW'((int'(ptr) + k) % NUM_REQ);
        if (req[cand]) idx = cand;
      end
    end
  end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Time-shares one 7-seg display among NUM_REQ sources.
// Ports: clk_i, rst_ni, bus (slave: req/seg/urgent in; seg/grant/busy/tick out).
module seg7_display_scheduler
  import seg7_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_DIV    = 20_000_000,
  parameter int DWELL_TICKS = 8,
  parameter int BLANK_TICKS = 1
) (
  input logic clk_i,
  input logic rst_ni,
  seg7_display_scheduler_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL_TICKS + 2);
  localparam int BW = $clog2(BLANK_TICKS + 2);

  state_e state_q, state_d;

  logic [PW-1:0] cnt_q;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          f0_q, f0_d;

  logic               tick;
  logic               ug;
  logic               others;
  logic               any_req;
  logic               leave;
  logic               grant_now;
  logic               pick_v;
  logic [IW-1:0]      pick_i;
  logic [NUM_REQ-1:0] own_oh;
  logic [6:0]         own_seg;

  assign tick    = cnt_q == PW'(TICK_DIV - 1);
  assign ug      = bus.urgent_i & bus.req_i[0];
  assign any_req = |bus.req_i;
  assign own_oh  = NUM_REQ'(1) << own_q;
  assign others  = |(bus.req_i & ~own_oh);

  assign bus.tick_o = tick;

  seg7_rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .force0(f0_q | ug),
    .valid (pick_v),
    .idx   (pick_i)
  );

  always_comb begin
    own_seg = SEG_BLANK;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (own_q == IW'(k)) own_seg = bus.seg_i[7*k +: 7];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      dwell_q <= '0;
      blank_q <= '0;
      f0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      f0_q    <= f0_d;
    end
  end

  // Outputs are registered from the current
  // state, so they trail the FSM by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.seg_o   <= SEG_BLANK;
      bus.grant_o <= '0;
      bus.busy_o  <= 1'b0;
    end else begin
      bus.busy_o <= state_q != IDLE;
      if (state_q == SHOW) begin
        bus.seg_o   <= own_seg;
        bus.grant_o <= own_oh;
      end else begin
        bus.seg_o   <= SEG_BLANK;
        bus.grant_o <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    dwell_d   = dwell_q;
    blank_d   = blank_q;
    f0_d      = f0_q;
    leave     = 1'b0;
    grant_now = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) grant_now = 1'b1;
      end
      SHOW: begin
        // Owner drop outranks preempt and dwell expiry.
        if (!(|(bus.req_i & own_oh))) begin
          leave = 1'b1;
        end else if (ug && own_q != '0) begin
          leave = 1'b1;
          f0_d  = 1'b1;
        end else if (tick) begin
          if (dwell_q == DW'(1)) begin
            if (others) leave = 1'b1;
            else dwell_d = DW'(DWELL_TICKS);
          end else begin
            dwell_d = dwell_q - DW'(1);
          end
        end
      end
      BLANK: begin
        if (ug) f0_d = 1'b1;
        if (tick) begin
          if (blank_q == BW'(1)) begin
            if (pick_v) begin
              grant_now = 1'b1;
            end else begin
              state_d = IDLE;
              f0_d    = 1'b0;
            end
          end else begin
            blank_d = blank_q - BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (leave) begin
      if (!any_req) begin
        state_d = IDLE;
        f0_d    = 1'b0;
      end else if (BLANK_TICKS == 0) begin
        grant_now = 1'b1;
      end else begin
        state_d = BLANK;
        blank_d = BW'(BLANK_TICKS);
      end
    end

    if (grant_now) begin
      state_d = SHOW;
      own_d   = pick_i;
      ptr_d   = pick_i;
      dwell_d = DW'(DWELL_TICKS);
      f0_d    = 1'b0;
    end
  end

endmodule
